// File: rtl/herring_pkg.sv
// herring_pkg: shared PHI2 sequencer state encodings, clock defaults and slow-window constants
package herring_pkg;
   typedef enum logic [1:0] {
      ST_LOW     = 2'd0,
      ST_HIGH    = 2'd1,
      ST_STRETCH = 2'd2,
      ST_HALT    = 2'd3
   } state_e;
   localparam int         DEF_HALF_PERIOD = 16;
   localparam int         DEF_SLOW_EXTRA  = 48;
   localparam logic [5:0] SLOW_SERIAL1    = 6'b111110;
   localparam logic [5:0] SLOW_MASK_ALL   = 6'b111111;
   function automatic int cnt_width(input int a, input int b);
      return $clog2(((a > b) ? a : b) + 1);
   endfunction
endpackage

// File: rtl/herring_addr_match.sv
// herring_addr_match: combinational compare of CPU address[15:10] against a masked window
//   address_i [5:0] in  : CPU address[15:10]
//   match_o         out : 1 when the masked address equals the masked base
module herring_addr_match #(
   parameter logic [5:0] BASE = 6'b111110,
   parameter logic [5:0] MASK = 6'b111111
) (
   input  logic [5:0] address_i,
   output logic       match_o
);
   assign match_o = (address_i & MASK) == (BASE & MASK);
endmodule

// File: rtl/herring_clock_sequencer.sv
// herring_clock_sequencer: PHI2 generator with slow-peripheral stretch, run/halt and single-step
//   clk_src_i      in  : 50 MHz source clock, rising edge
//   rst_n_i        in  : synchronous active-low reset
//   address_i[5:0] in  : CPU address[15:10]
//   rw_i           in  : CPU RWB, 1 = read
//   run_i          in  : 1 = free-run, 0 = halt after the current cycle
//   step_i         in  : single-step request, rising edge acts while halted
//   cpu_clk_in_o   out : registered PHI2
//   cycle_start_o  out : one-clock pulse on the edge where PHI2 rises
//   stretched_o    out : high while the PHI2-high phase is extended
//   halted_o       out : high while PHI2 is parked low
module herring_clock_sequencer
   import herring_pkg::*;
#(
   parameter int         HALF_PERIOD    = DEF_HALF_PERIOD,
   parameter int         SLOW_EXTRA     = DEF_SLOW_EXTRA,
   parameter logic [5:0] SLOW_BASE      = SLOW_SERIAL1,
   parameter logic [5:0] SLOW_MASK      = SLOW_MASK_ALL,
   parameter bit         STRETCH_WRITES = 1'b1
) (
   input  logic       clk_src_i,
   input  logic       rst_n_i,
   input  logic [5:0] address_i,
   input  logic       rw_i,
   input  logic       run_i,
   input  logic       step_i,
   output logic       cpu_clk_in_o,
   output logic       cycle_start_o,
   output logic       stretched_o,
   output logic       halted_o
);
   localparam int            CW      = cnt_width(HALF_PERIOD, SLOW_EXTRA);
   localparam logic [CW-1:0] HP_LAST = CW'(HALF_PERIOD - 1);
   localparam logic [CW-1:0] SE_LAST = CW'(SLOW_EXTRA - 1);
   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          slow_q, slow_d, step_q, match, slow_now, step_rise;
   logic          clk_q, start_q, str_q, halt_q;
   logic          clk_d, start_d, str_d, halt_d;
   herring_addr_match #(.BASE(SLOW_BASE), .MASK(SLOW_MASK)) u_match (
      .address_i (address_i),
      .match_o   (match)
   );
   assign slow_now  = match & (rw_i | STRETCH_WRITES);
   assign step_rise = step_i & ~step_q;
   always_comb begin
      state_d = state_q;
      slow_d  = slow_q;
      case (state_q)
         ST_LOW: if (cnt_q == HP_LAST) begin
            slow_d  = slow_now;
            state_d = run_i ? ST_HIGH : ST_HALT;
         end
         ST_HIGH: if (cnt_q == HP_LAST)
            state_d = (slow_q && (SLOW_EXTRA > 0)) ? ST_STRETCH : ST_LOW;
         ST_STRETCH: if (cnt_q == SE_LAST)
            state_d = ST_LOW;
         default: if (run_i | step_rise) begin
            slow_d  = slow_now;
            state_d = ST_HIGH;
         end
      endcase
      // counter parks at zero while halted so it can never wrap
      cnt_d = ((state_d != state_q) || (state_d == ST_HALT)) ? '0 : cnt_q + 1'b1;
   end
   // outputs are decoded from the next state and registered, so they line up with state_q
   always_comb begin
      clk_d   = (state_d == ST_HIGH) || (state_d == ST_STRETCH);
      start_d = (state_d == ST_HIGH) && (state_q != ST_HIGH);
      str_d   = state_d == ST_STRETCH;
      halt_d  = state_d == ST_HALT;
   end
   always_ff @(posedge clk_src_i) begin
      if (!rst_n_i) begin
         state_q <= ST_LOW;
         cnt_q   <= '0;
         slow_q  <= 1'b0;
         step_q  <= 1'b0;
         clk_q   <= 1'b0;
         start_q <= 1'b0;
         str_q   <= 1'b0;
         halt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         slow_q  <= slow_d;
         step_q  <= step_i;
         clk_q   <= clk_d;
         start_q <= start_d;
         str_q   <= str_d;
         halt_q  <= halt_d;
      end
   end
   assign cpu_clk_in_o  = clk_q;
   assign cycle_start_o = start_q;
   assign stretched_o   = str_q;
   assign halted_o      = halt_q;
endmodule

// File: tb/tb_herring_clock_sequencer.sv
// tb_herring_clock_sequencer: randomized scoreboard bench for the PHI2 sequencer
`timescale 1ns/1ps
module tb_herring_clock_sequencer;
   localparam int H = 16;
   localparam int E = 48;
   typedef struct {
      int hi;
      int st;
      int lo;
   } exp_t;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] addr [2];
   logic       rw   [2];
   logic       run  [2];
   logic       step [2];
   logic       pclk [2];
   logic       cs   [2];
   logic       str  [2];
   logic       hlt  [2];
   exp_t       expq [2][$];
   int         errors = 0;
   int         checks = 0;
   int         ncs0   = 0;
   bit         done0  = 1'b0;
   always #10 clk = ~clk;
   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
      end
   endtask
   function automatic bit is_slow(input logic [5:0] a, input logic r, input bit sw);
      return (a == 6'b111110) && (r || sw);
   endfunction
   task automatic push(input int g);
      exp_t e;
      bit   s;
      s    = is_slow(addr[g], rw[g], g == 0);
      e.hi = H + (s ? E : 0);
      e.st = s ? E : 0;
      e.lo = H;
      expq[g].push_back(e);
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic wait_cs(input int g);
      bit ok = 1'b0;
      for (int n = 0; n < 200 && !ok; n++) begin
         tick();
         ok = cs[g];
      end
      chk("cycle_start_seen", int'(ok), 1);
   endtask
   task automatic commit(input int g);
      repeat ($urandom_range(0, 8)) begin
         addr[g] = 6'($urandom);
         rw[g]   = 1'($urandom);
         step[g] = 1'($urandom);
         tick();
      end
      addr[g] = $urandom_range(0, 1) ? 6'b111110 : 6'($urandom);
      rw[g]   = 1'($urandom);
      step[g] = 1'b0;
      push(g);
   endtask
   task automatic free_run(input int g, input int n, input bit skip);
      for (int i = 0; i < n; i++) begin
         if (!(skip && i == 0)) wait_cs(g);
         commit(g);
      end
   endtask
   task automatic first_rise();
      int n    = 0;
      bit seen = 1'b0;
      while (!seen && n < 40) begin
         tick();
         n++;
         seen = pclk[0];
      end
      chk("first_rise_clks", n, H);
      chk("first_rise_inst1", int'(pclk[1]), 1);
   endtask
   task automatic drain(input int g);
      bit ok = 1'b0;
      for (int n = 0; n < 300 && !ok; n++) begin
         tick();
         ok = expq[g].size() == 0;
      end
      chk("drain_last_cycle", int'(ok), 1);
      run[g] = 1'b0;
      ok = 1'b0;
      for (int n = 0; n < 300 && !ok; n++) begin
         tick();
         ok = hlt[g];
      end
      chk("drain_halted", int'(ok), 1);
   endtask
   for (genvar g = 0; g < 2; g++) begin : dut
      int   ph = 0;
      int   hi = 0;
      int   st = 0;
      int   lo = 0;
      exp_t e;
      herring_clock_sequencer #(.STRETCH_WRITES(g == 0)) u (
         .clk_src_i     (clk),
         .rst_n_i       (rst_n),
         .address_i     (addr[g]),
         .rw_i          (rw[g]),
         .run_i         (run[g]),
         .step_i        (step[g]),
         .cpu_clk_in_o  (pclk[g]),
         .cycle_start_o (cs[g]),
         .stretched_o   (str[g]),
         .halted_o      (hlt[g])
      );
      always @(negedge clk) begin
         if (!rst_n) begin
            ph = 0;
            expq[g].delete();
         end else if (cs[g]) begin
            if (ph == 2) chk("low_len", lo, e.lo);
            if (expq[g].size() == 0) begin
               chk("unexpected_cycle_queue", expq[g].size(), 1);
               ph = 0;
            end else begin
               e  = expq[g].pop_front();
               hi = 1;
               st = 0;
               ph = 1;
            end
         end else if (ph == 1) begin
            if (pclk[g]) begin
               hi++;
               st += int'(str[g]);
            end else begin
               chk("high_len", hi, e.hi);
               chk("stretch_len", st, e.st);
               lo = 1;
               ph = 2;
            end
         end else if (ph == 2) begin
            if (hlt[g]) begin
               chk("low_len_before_halt", lo, e.lo);
               ph = 0;
            end else lo++;
         end
      end
   end
   always @(negedge clk) if (rst_n && cs[0]) ncs0++;
   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int base;
      rst_n = 1'b0;
      for (int g = 0; g < 2; g++) begin
         addr[g] = 6'b000000;
         rw[g]   = 1'b1;
         run[g]  = 1'b1;
         step[g] = 1'b0;
      end
      repeat (3) tick();
      for (int g = 0; g < 2; g++) begin
         chk("reset_phi2", int'(pclk[g]), 0);
         chk("reset_cycle_start", int'(cs[g]), 0);
         chk("reset_stretched", int'(str[g]), 0);
         chk("reset_halted", int'(hlt[g]), 0);
      end
      rst_n = 1'b1;
      push(0);
      push(1);
      first_rise();
      fork
         begin
            free_run(0, 12, 1'b1);
            wait_cs(0);
            repeat (5) tick();
            run[0] = 1'b0;
            for (int n = 0; n < 200 && !hlt[0]; n++) tick();
            chk("halt_reached", int'(hlt[0]), 1);
            chk("halt_phi2_low", int'(pclk[0]), 0);
            base = ncs0;
            repeat (3) begin
               addr[0] = $urandom_range(0, 1) ? 6'b111110 : 6'($urandom);
               rw[0]   = 1'($urandom);
               push(0);
               step[0] = 1'b1;
               tick();
               step[0] = 1'b0;
               repeat (99) tick();
               chk("halted_after_step", int'(hlt[0]), 1);
            end
            chk("three_step_cycles", ncs0 - base, 3);
            base    = ncs0;
            addr[0] = 6'b111110;
            rw[0]   = 1'b1;
            push(0);
            step[0] = 1'b1;
            repeat (50) tick();
            step[0] = 1'b0;
            repeat (100) tick();
            chk("held_step_cycles", ncs0 - base, 1);
            addr[0] = 6'($urandom);
            rw[0]   = 1'($urandom);
            push(0);
            run[0]  = 1'b1;
            step[0] = 1'b1;
            tick();
            step[0] = 1'b0;
            chk("run_step_exit", int'(cs[0]), 1);
            free_run(0, 4, 1'b1);
            done0 = 1'b1;
         end
         begin
            free_run(1, 1, 1'b1);
            while (!done0) free_run(1, 1, 1'b0);
            drain(1);
         end
      join
      wait_cs(0);
      addr[0] = 6'b111110;
      rw[0]   = 1'b1;
      push(0);
      for (int n = 0; n < 300 && !str[0]; n++) tick();
      chk("stretch_before_reset", int'(str[0]), 1);
      rst_n  = 1'b0;
      run[1] = 1'b1;
      tick();
      chk("midreset_phi2", int'(pclk[0]), 0);
      chk("midreset_stretched", int'(str[0]), 0);
      chk("midreset_cycle_start", int'(cs[0]), 0);
      chk("midreset_halted", int'(hlt[0]), 0);
      rst_n = 1'b1;
      push(0);
      push(1);
      first_rise();
      fork
         free_run(0, 6, 1'b1);
         free_run(1, 6, 1'b1);
      join
      fork
         drain(0);
         drain(1);
      join
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
